// File: rtl/unidade_busca_instrucao.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order memory requests under a
// credit limit, buffers returned words and hands {pc, instr} pairs downstream.

module unidade_busca_instrucao_chk #(
  parameter int unsigned CW    = 3,
  parameter int unsigned DEPTH = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_resp_valid,
  input  logic [CW-1:0] i_inflight,
  input  logic [CW-1:0] i_count
);
  // A response with nothing outstanding is a memory-side protocol error.
  a_no_orphan_resp: assert property (@(posedge i_clk) disable iff (!i_rst)
    i_resp_valid |-> (i_inflight != '0));
  a_credit_bound: assert property (@(posedge i_clk) disable iff (!i_rst)
    (i_inflight + i_count) <= CW'(DEPTH));
endmodule

module unidade_busca_instrucao #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] PCOut
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(2 * DEPTH + 1);

  logic [XLEN-1:0] r_fetch_pc;
  logic [CW-1:0]   r_inflight;
  logic [CW-1:0]   r_drop;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_buf_wr;
  logic [PW-1:0]   r_buf_rd;
  logic [PW-1:0]   r_pcq_wr;
  logic [PW-1:0]   r_pcq_rd;
  logic [XLEN-1:0] r_pcout;
  logic [XLEN-1:0] r_buf_pc    [DEPTH];
  logic [ILEN-1:0] r_buf_instr [DEPTH];
  logic [XLEN-1:0] r_pcq       [DEPTH];

  logic            w_req_fire;
  logic            w_resp_hit;
  logic            w_resp_keep;
  logic            w_pop;
  logic [CW-1:0]   w_credit_used;
  logic [CW-1:0]   w_inflight_nx;
  logic [CW-1:0]   w_drop_nx;
  logic [CW-1:0]   w_count_nx;
  logic [XLEN-1:0] w_fetch_pc_nx;
  logic            w_unused;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PW'(1);
    end
  endfunction

  // Requests stop once in-flight plus buffered words would exceed the buffer.
  assign w_credit_used  = r_inflight + r_count;
  assign imem_req_valid = rst & (w_credit_used < CW'(DEPTH)) & ~redirect_valid;
  assign imem_req_addr  = r_fetch_pc;

  assign out_valid = (r_count != '0);
  assign out_pc    = out_valid ? r_buf_pc[r_buf_rd]    : '0;
  assign out_instr = out_valid ? r_buf_instr[r_buf_rd] : '0;
  assign PCOut     = r_pcout;

  assign w_req_fire  = imem_req_valid & imem_req_ready;
  assign w_resp_hit  = rst & imem_resp_valid & (r_inflight != '0);
  assign w_resp_keep = w_resp_hit & ~redirect_valid & (r_drop == '0);
  assign w_pop       = out_valid & out_ready;
  assign w_unused    = ^redirect_pc[1:0];

  // Next-state for PC and counters; a redirect marks every outstanding request as stale.
  always_comb begin
    w_inflight_nx = r_inflight + (w_req_fire ? CW'(1) : CW'(0)) - (w_resp_hit ? CW'(1) : CW'(0));
    w_drop_nx     = r_drop;
    w_count_nx    = r_count;
    w_fetch_pc_nx = r_fetch_pc;
    if (redirect_valid) begin
      w_drop_nx     = r_inflight - (w_resp_hit ? CW'(1) : CW'(0));
      w_count_nx    = '0;
      w_fetch_pc_nx = {redirect_pc[XLEN-1:2], 2'b00};
    end else begin
      w_drop_nx     = (w_resp_hit && (r_drop != '0)) ? (r_drop - CW'(1)) : r_drop;
      w_count_nx    = r_count + (w_resp_keep ? CW'(1) : CW'(0)) - (w_pop ? CW'(1) : CW'(0));
      w_fetch_pc_nx = w_req_fire ? (r_fetch_pc + XLEN'(4)) : r_fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_inflight <= '0;
      r_drop     <= '0;
      r_count    <= '0;
      r_buf_wr   <= '0;
      r_buf_rd   <= '0;
      r_pcq_wr   <= '0;
      r_pcq_rd   <= '0;
      r_pcout    <= '0;
    end else begin
      r_fetch_pc <= w_fetch_pc_nx;
      r_inflight <= w_inflight_nx;
      r_drop     <= w_drop_nx;
      r_count    <= w_count_nx;
      r_pcq_wr   <= w_req_fire ? ptr_inc(r_pcq_wr) : r_pcq_wr;
      r_pcq_rd   <= w_resp_hit ? ptr_inc(r_pcq_rd) : r_pcq_rd;
      if (redirect_valid) begin
        r_buf_wr <= '0;
        r_buf_rd <= '0;
      end else begin
        r_buf_wr <= w_resp_keep ? ptr_inc(r_buf_wr) : r_buf_wr;
        r_buf_rd <= w_pop ? ptr_inc(r_buf_rd) : r_buf_rd;
      end
      if (w_pop) begin
        r_pcout <= out_pc;
      end
    end
  end

  // Storage is only read while counted valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_pcq[r_pcq_wr] <= r_fetch_pc;
    end
    if (w_resp_keep) begin
      r_buf_pc[r_buf_wr]    <= r_pcq[r_pcq_rd];
      r_buf_instr[r_buf_wr] <= imem_resp_data;
    end
  end

  unidade_busca_instrucao_chk #(
    .CW    (CW),
    .DEPTH (DEPTH)
  ) u_chk (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_resp_valid (imem_resp_valid),
    .i_inflight   (r_inflight),
    .i_count      (r_count)
  );
endmodule

// File: tb/tb_unidade_busca_instrucao.sv
// Bench for unidade_busca_instrucao: directed scenarios plus a randomized run checked
// against an epoch-tagged queue model of the fetch stream.
module tb_unidade_busca_instrucao;
  localparam int unsigned DEPTH    = 2;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [63:0] PCOut;

  typedef struct { logic [63:0] addr; int epoch; int rdy; } req_t;
  typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;

  req_t        mem_q[$];
  ent_t        m_out[$];
  int          epoch, cyc, lat_min, lat_max;
  logic [63:0] exp_fetch, exp_pcout;
  int          n_vec, n_miss;

  unidade_busca_instrucao #(
    .XLEN(64), .ILEN(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .PCOut(PCOut)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[33:2] * 32'h9E37_79B1) ^ a[63:32];
  endfunction

  // Advance one clock: update the reference model with the inputs sampled at the edge,
  // then drive the memory response for the next cycle at the falling edge.
  task automatic tick();
    req_t r;
    logic fire, hs;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      mem_q.delete();
      m_out.delete();
      epoch++;
      exp_fetch = RESET_PC;
      exp_pcout = 64'h0;
    end else begin
      fire = ((mem_q.size() + m_out.size()) < DEPTH) && !redirect_valid && imem_req_ready;
      hs   = (m_out.size() > 0) && out_ready;
      if (hs) begin
        exp_pcout = m_out[0].pc;
        void'(m_out.pop_front());
      end
      if (imem_resp_valid) begin
        r = mem_q.pop_front();
        if (r.epoch == epoch) m_out.push_back('{pc: r.addr, instr: mem_word(r.addr)});
      end
      if (fire) begin
        mem_q.push_back('{addr: exp_fetch, epoch: epoch,
                          rdy: cyc + int'($urandom_range(lat_max, lat_min))});
        exp_fetch = exp_fetch + 64'd4;
      end
      if (redirect_valid) begin
        m_out.delete();
        epoch++;
        exp_fetch = {redirect_pc[63:2], 2'b00};
      end
    end
    @(negedge clk);
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    if (mem_q.size() > 0) begin
      if (mem_q[0].rdy <= cyc + 1) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mem_q[0].addr);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0; imem_req_ready = 1'b1;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    lat_min = 1; lat_max = 1;
    rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1; imem_req_ready = 1'b1;
    tick(); tick();
    #1;
    n_vec++; if (imem_req_valid !== 1'b0) begin n_miss++; $display("FAIL reset_req_valid got %b want 0", imem_req_valid); end
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (out_pc !== 64'h0 || out_instr !== 32'h0) begin n_miss++; $display("FAIL reset_out_data got %h/%h want 0/0", out_pc, out_instr); end
    n_vec++; if (PCOut !== 64'h0) begin n_miss++; $display("FAIL reset_pcout got %h want 0", PCOut); end
    rst = 1'b1;
    #1;
    n_vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin n_miss++; $display("FAIL reset_first_req got %b/%h want 1/%h", imem_req_valid, imem_req_addr, RESET_PC); end
  endtask

  task automatic test_stream();
    logic [63:0] exp_req, exp_out, last_pc;
    logic had_hs;
    int nout;
    lat_min = 1; lat_max = 1;
    do_reset();
    out_ready = 1'b1;
    exp_req = 64'h0; exp_out = 64'h0; last_pc = 64'h0; had_hs = 1'b0; nout = 0;
    for (int c = 0; c < 24; c++) begin
      #1;
      if (had_hs) begin
        n_vec++; if (PCOut !== last_pc) begin n_miss++; $display("FAIL stream_pcout got %h want %h", PCOut, last_pc); end
      end
      if (imem_req_valid) begin
        n_vec++; if (imem_req_addr !== exp_req) begin n_miss++; $display("FAIL stream_addr got %h want %h", imem_req_addr, exp_req); end
        exp_req = exp_req + 64'd4;
      end
      had_hs = out_valid;
      if (out_valid) begin
        n_vec++; if (out_pc !== exp_out || out_instr !== mem_word(exp_out)) begin n_miss++; $display("FAIL stream_out got %h/%h want %h/%h", out_pc, out_instr, exp_out, mem_word(exp_out)); end
        last_pc = exp_out; exp_out = exp_out + 64'd4; nout++;
      end
      tick();
    end
    n_vec++; if (nout < 8) begin n_miss++; $display("FAIL stream_count got %0d want >=8", nout); end
  endtask

  task automatic test_backpressure();
    int nreq, nout;
    logic [63:0] exp_out;
    lat_min = 1; lat_max = 1;
    do_reset();
    out_ready = 1'b0; nreq = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (imem_req_valid) nreq++;
      tick();
    end
    #1;
    n_vec++; if (nreq != 2) begin n_miss++; $display("FAIL bp_req_count got %0d want 2", nreq); end
    n_vec++; if (imem_req_valid !== 1'b0) begin n_miss++; $display("FAIL bp_req_stall got %b want 0", imem_req_valid); end
    n_vec++; if (out_valid !== 1'b1 || out_pc !== 64'h0) begin n_miss++; $display("FAIL bp_hold got %b/%h want 1/0", out_valid, out_pc); end
    out_ready = 1'b1; exp_out = 64'h0; nout = 0;
    for (int c = 0; c < 40 && nout < 6; c++) begin
      if (out_valid) begin
        n_vec++; if (out_pc !== exp_out) begin n_miss++; $display("FAIL bp_resume got %h want %h", out_pc, exp_out); end
        exp_out = exp_out + 64'd4; nout++;
      end
      tick(); #1;
    end
    n_vec++; if (nout != 6) begin n_miss++; $display("FAIL bp_resume_count got %0d want 6", nout); end
  endtask

  task automatic test_redirect_drop();
    int k;
    lat_min = 3; lat_max = 3;
    do_reset();
    out_ready = 1'b1;
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 64'h100;
    #1;
    n_vec++; if (imem_req_valid !== 1'b0) begin n_miss++; $display("FAIL rd_no_req got %b want 0", imem_req_valid); end
    tick();
    redirect_valid = 1'b0;
    k = 0; #1;
    while (out_valid !== 1'b1 && k < 40) begin tick(); #1; k++; end
    n_vec++; if (out_pc !== 64'h100) begin n_miss++; $display("FAIL rd_first got %h want 100", out_pc); end
    tick();
    k = 0; #1;
    while (out_valid !== 1'b1 && k < 40) begin tick(); #1; k++; end
    n_vec++; if (out_pc !== 64'h104) begin n_miss++; $display("FAIL rd_second got %h want 104", out_pc); end
  endtask

  task automatic test_redirect_handshake();
    int k;
    lat_min = 1; lat_max = 1;
    do_reset();
    out_ready = 1'b1;
    k = 0; #1;
    while (!(out_valid === 1'b1 && out_pc === 64'h8) && k < 40) begin tick(); #1; k++; end
    n_vec++; if (k >= 40) begin n_miss++; $display("FAIL rh_wait got timeout want pc 8"); end
    redirect_valid = 1'b1; redirect_pc = 64'h103;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_vec++; if (PCOut !== 64'h8) begin n_miss++; $display("FAIL rh_pcout got %h want 8", PCOut); end
    n_vec++; if (imem_req_addr !== 64'h100) begin n_miss++; $display("FAIL rh_addr got %h want 100", imem_req_addr); end
    k = 0;
    while (out_valid !== 1'b1 && k < 40) begin tick(); #1; k++; end
    n_vec++; if (out_pc !== 64'h100) begin n_miss++; $display("FAIL rh_out got %h want 100", out_pc); end
    tick(); #1;
    n_vec++; if (PCOut !== 64'h100) begin n_miss++; $display("FAIL rh_pcout2 got %h want 100", PCOut); end
  endtask

  task automatic test_wrap();
    logic [63:0] exp_seq [3];
    int nout;
    exp_seq[0] = 64'hFFFF_FFFF_FFFF_FFFC; exp_seq[1] = 64'h0; exp_seq[2] = 64'h4;
    lat_min = 1; lat_max = 2;
    do_reset();
    out_ready = 1'b1;
    tick();
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    nout = 0; #1;
    for (int c = 0; c < 60 && nout < 3; c++) begin
      if (out_valid) begin
        n_vec++; if (out_pc !== exp_seq[nout]) begin n_miss++; $display("FAIL wrap_seq got %h want %h", out_pc, exp_seq[nout]); end
        nout++;
      end
      tick(); #1;
    end
    n_vec++; if (nout != 3) begin n_miss++; $display("FAIL wrap_count got %0d want 3", nout); end
  endtask

  task automatic test_reset_midstream();
    int k;
    lat_min = 3; lat_max = 3;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) tick();
    rst = 1'b0; imem_req_ready = 1'b1;
    #1;
    n_vec++; if (imem_req_valid !== 1'b0) begin n_miss++; $display("FAIL rm_req_in_reset got %b want 0", imem_req_valid); end
    tick(); #1;
    n_vec++; if (out_valid !== 1'b0 || out_pc !== 64'h0 || out_instr !== 32'h0 || PCOut !== 64'h0) begin
      n_miss++; $display("FAIL rm_outputs got %b/%h/%h/%h want 0", out_valid, out_pc, out_instr, PCOut); end
    n_vec++; if (imem_req_valid !== 1'b0) begin n_miss++; $display("FAIL rm_req_held got %b want 0", imem_req_valid); end
    tick();
    rst = 1'b1;
    #1;
    n_vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin n_miss++; $display("FAIL rm_restart got %b/%h want 1/%h", imem_req_valid, imem_req_addr, RESET_PC); end
    k = 0;
    while (out_valid !== 1'b1 && k < 40) begin tick(); #1; k++; end
    n_vec++; if (out_pc !== RESET_PC) begin n_miss++; $display("FAIL rm_first_out got %h want %h", out_pc, RESET_PC); end
  endtask

  task automatic test_random();
    logic exp_rv;
    lat_min = 1; lat_max = 4;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      out_ready      = ($urandom_range(3, 0) != 0);
      redirect_valid = ($urandom_range(15, 0) == 0);
      redirect_pc    = ($urandom_range(1, 0) == 1) ? {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom)}
                                                   : {32'h0, $urandom};
      rst            = ($urandom_range(199, 0) != 0);
      #1;
      exp_rv = rst && ((mem_q.size() + m_out.size()) < DEPTH) && !redirect_valid;
      n_vec++; if (imem_req_valid !== exp_rv) begin n_miss++; $display("FAIL rnd_req_valid c=%0d got %b want %b", c, imem_req_valid, exp_rv); end
      if (rst) begin
        n_vec++; if (imem_req_addr !== exp_fetch) begin n_miss++; $display("FAIL rnd_addr c=%0d got %h want %h", c, imem_req_addr, exp_fetch); end
      end
      n_vec++; if (out_valid !== (m_out.size() > 0)) begin n_miss++; $display("FAIL rnd_out_valid c=%0d got %b want %b", c, out_valid, m_out.size() > 0); end
      if (m_out.size() > 0) begin
        n_vec++; if (out_pc !== m_out[0].pc || out_instr !== m_out[0].instr) begin
          n_miss++; $display("FAIL rnd_out c=%0d got %h/%h want %h/%h", c, out_pc, out_instr, m_out[0].pc, m_out[0].instr); end
      end
      n_vec++; if (PCOut !== exp_pcout) begin n_miss++; $display("FAIL rnd_pcout c=%0d got %h want %h", c, PCOut, exp_pcout); end
      tick();
    end
    rst = 1'b1; redirect_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0; rst = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0; redirect_valid = 1'b0; redirect_pc = 64'h0; out_ready = 1'b0;
    epoch = 0; cyc = 0; lat_min = 1; lat_max = 1;
    exp_fetch = RESET_PC; exp_pcout = 64'h0; n_vec = 0; n_miss = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_handshake();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
